load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit: byte-serial, big-endian load/store engine.
// Splits halfword/word requests into single-byte memory cycles.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              align_err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP,
        ERR
    } state_t;

    typedef struct packed {
        logic              rw;
        logic [1:0]        size;
        logic              sgn;
        logic [ADDR_W-1:0] base;
    } req_t;

    state_t      state;
    state_t      state_nxt;
    req_t        req_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_last;
    logic        last;
    logic [31:0] wsh_q;
    logic [31:0] asm_q;
    logic [31:0] asm_nxt;
    logic        accept;
    logic        illegal;
    logic        misalign;
    logic        unused_addr_hi;

    // Upper address bits wrap away; only the low ADDR_W bits matter.
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    assign accept   = req_valid && req_ready;
    assign illegal  = (req_size == 2'b11);
    assign misalign = ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Index of the final byte: 0, 1 or 3 for byte, half, word.
    assign cnt_last = {req_q.size[1], req_q.size[1] | req_q.size[0]};
    assign last     = (cnt_q == cnt_last);

    // Incoming byte lands in the low lane; earlier bytes move up.
    assign asm_nxt  = {asm_q[23:0], mem_rdata};

    assign mem_addr  = req_q.base + ADDR_W'(cnt_q);
    assign mem_wdata = wsh_q[31:24];

    // Sign- or zero-extend the assembled 8N-bit load value.
    function automatic logic [31:0] extend(
        input logic [31:0] v,
        input logic [1:0]  sz,
        input logic        sgn
    );
        logic [31:0] r;
        r = v;
        unique case (sz)
            2'b00:   r = {{24{sgn & v[7]}}, v[7:0]};
            2'b01:   r = {{16{sgn & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        resp_valid = 1'b0;
        align_err  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = (illegal || misalign) ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_rw = req_q.rw;
                if (last) begin
                    state_nxt = req_q.rw ? RESP : CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            ERR: begin
                align_err = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, byte counter, store shifter and load assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            cnt_q <= 2'd0;
            wsh_q <= 32'h0;
            asm_q <= 32'h0;
        end else if (accept) begin
            req_q.rw   <= req_rw;
            req_q.size <= req_size;
            req_q.sgn  <= req_signed;
            req_q.base <= req_addr[ADDR_W-1:0];
            cnt_q      <= 2'd0;
            asm_q      <= 32'h0;
            // Left-justify so the most significant byte goes out first.
            unique case (req_size)
                2'b00:   wsh_q <= {req_wdata[7:0], 24'h0};
                2'b01:   wsh_q <= {req_wdata[15:0], 16'h0};
                default: wsh_q <= req_wdata;
            endcase
        end else if (state == ACCESS) begin
            cnt_q <= cnt_q + 2'd1;
            wsh_q <= {wsh_q[23:0], 8'h00};
            // Read data trails the strobe by one cycle.
            if (cnt_q != 2'd0) begin
                asm_q <= asm_nxt;
            end
        end else if (state == CAPTURE) begin
            asm_q <= asm_nxt;
        end
    end

    // Load result register, written on entry to RESP only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= 32'h0;
        end else if (state == CAPTURE) begin
            resp_rdata <= extend(asm_nxt, req_q.size, req_q.sgn);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// tb_load_store_unit: scoreboard bench with a 256-byte memory model.
// Expected responses and memory writes are queued as requests go out.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        align_err;
    logic        busy;
    logic        mem_en;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          ens;
    } exp_t;

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] d;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    exp_t        sbq[$];
    logic [15:0] wq[$];
    logic [7:0]  mem[256];
    logic [31:0] cur_rd = 32'h0;
    int          en_cnt = 0;
    int          total = 0;
    int          bad = 0;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .align_err  (align_err),
        .busy       (busy),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory model plus write-order monitor.
    initial begin
        logic [15:0] w;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                en_cnt++;
                if (mem_rw) begin
                    mem[mem_addr] <= mem_wdata;
                    total++;
                    if (wq.size() == 0) begin
                        bad++;
                        $display("FAIL wr_unexpected: addr=%h data=%h, required no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        w = wq.pop_front();
                        if ({mem_addr, mem_wdata} !== w) begin
                            bad++;
                            $display("FAIL wr_byte: addr/data=%h/%h, required %h/%h",
                                     mem_addr, mem_wdata, w[15:8], w[7:0]);
                        end
                    end
                end else begin
                    mem_rdata <= mem[mem_addr];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int waited);
        req_rw     = rw;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        waited     = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready=%0b, required 1", req_ready);
        end
        step();
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_size  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic issue(input logic rw, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic err, input logic [31:0] rd,
                         input bit hold, output int waited);
        exp_t e;
        int   n;
        n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e.err = err;
        e.lat = err ? 1 : (rw ? n + 1 : n + 2);
        e.ens = err ? 0 : n;
        if (!err && !rw) cur_rd = rd;
        e.data = cur_rd;
        if (!err && rw) begin
            for (int k = 0; k < n; k++) begin
                wq.push_back({a[7:0] + 8'(k), 8'(d >> (8 * (n - 1 - k)))});
            end
        end
        sbq.push_back(e);
        send(rw, sz, sg, a, d, hold, waited);
    endtask

    task automatic wait_resp(output logic gv, output logic ge,
                             output logic [31:0] gd, output int cyc,
                             output int ens, output int rh);
        int s;
        s   = en_cnt;
        gv  = 1'b0;
        ge  = 1'b0;
        cyc = 0;
        rh  = 0;
        for (int c = 1; c <= 20; c++) begin
            if (req_ready) rh++;
            if (resp_valid || align_err) begin
                gv  = resp_valid;
                ge  = align_err;
                cyc = c;
                break;
            end
            step();
        end
        gd  = resp_rdata;
        ens = en_cnt - s;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({busy, mem_en, resp_valid, align_err} !== 4'b0000 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: busy/en/vld/err=%b rdata=%h, required 0000 00000000",
                     {busy, mem_en, resp_valid, align_err}, resp_rdata);
        end
        rst = 1'b0;
        step();
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_store_load();
        vec_t t[11];
        exp_t e;
        logic gv, ge;
        logic [31:0] gd;
        int cyc, ens, rh, w;
        t[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0};
        t[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h1122_3344};
        t[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 1'b0, 32'h0000_3344};
        t[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_5680, 1'b0, 32'h0};
        t[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0, 1'b0, 32'hFFFF_FF80};
        t[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_0080};
        t[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_01FE, 32'h9999_ABCD, 1'b0, 32'h0};
        t[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_00FE, 32'h0, 1'b0, 32'hFFFF_ABCD};
        t[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_01FF, 32'h0000_005A, 1'b0, 32'h0};
        t[9]  = '{1'b0, 2'b01, 1'b0, 32'h7FFF_FFFE, 32'h0, 1'b0, 32'h0000_AB5A};
        t[10] = '{1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0, 1'b0, 32'h8022_3344};
        for (int i = 0; i < 11; i++) begin
            issue(t[i].rw, t[i].sz, t[i].sg, t[i].a, t[i].d, t[i].err, t[i].rd, 1'b0, w);
            wait_resp(gv, ge, gd, cyc, ens, rh);
            e = sbq.pop_front();
            total++;
            if (gv !== !e.err || ge !== e.err || cyc !== e.lat) begin
                bad++;
                $display("FAIL sl_resp[%0d]: vld=%b err=%b cycle=%0d, required vld=%b err=%b cycle=%0d",
                         i, gv, ge, cyc, !e.err, e.err, e.lat);
            end
            total++;
            if (gd !== e.data) begin
                bad++;
                $display("FAIL sl_rdata[%0d]: got %h, required %h", i, gd, e.data);
            end
            total++;
            if (ens !== e.ens || rh !== 0) begin
                bad++;
                $display("FAIL sl_mem[%0d]: en_cycles=%0d ready_hi=%0d, required %0d 0",
                         i, ens, rh, e.ens);
            end
            step();
        end
        total++;
        if (wq.size() !== 0 || mem[8'hFE] !== 8'hAB || mem[8'hFF] !== 8'h5A) begin
            bad++;
            $display("FAIL sl_final: pending=%0d mem[FE]=%h mem[FF]=%h, required 0 ab 5a",
                     wq.size(), mem[8'hFE], mem[8'hFF]);
        end
    endtask

    task automatic test_align_err();
        vec_t t[5];
        exp_t e;
        logic gv, ge;
        logic [31:0] gd;
        int cyc, ens, rh, w;
        t[0] = '{1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'h0};
        t[1] = '{1'b0, 2'b01, 1'b1, 32'h0000_0001, 32'h0, 1'b1, 32'h0};
        t[2] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0};
        t[3] = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_7777, 1'b1, 32'h0};
        t[4] = '{1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h5555_5555, 1'b1, 32'h0};
        for (int i = 0; i < 5; i++) begin
            issue(t[i].rw, t[i].sz, t[i].sg, t[i].a, t[i].d, t[i].err, t[i].rd, 1'b0, w);
            wait_resp(gv, ge, gd, cyc, ens, rh);
            e = sbq.pop_front();
            total++;
            if (gv !== !e.err || ge !== e.err || cyc !== e.lat) begin
                bad++;
                $display("FAIL ae_resp[%0d]: vld=%b err=%b cycle=%0d, required vld=%b err=%b cycle=%0d",
                         i, gv, ge, cyc, !e.err, e.err, e.lat);
            end
            total++;
            if (gd !== e.data || ens !== 0) begin
                bad++;
                $display("FAIL ae_quiet[%0d]: rdata=%h en_cycles=%0d, required %h 0",
                         i, gd, ens, e.data);
            end
            step();
            total++;
            if (align_err !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL ae_pulse[%0d]: err=%b ready=%b, required 0 1", i, align_err, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t t[3];
        exp_t e;
        logic gv, ge;
        logic [31:0] gd;
        int cyc, ens, rh, w;
        t[0] = '{1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, 32'h0};
        t[1] = '{1'b0, 2'b10, 1'b1, 32'h0000_0030, 32'h0, 1'b0, 32'hCAFE_F00D};
        t[2] = '{1'b0, 2'b00, 1'b1, 32'h0000_0031, 32'h0, 1'b0, 32'hFFFF_FFFE};
        for (int i = 0; i < 3; i++) begin
            issue(t[i].rw, t[i].sz, t[i].sg, t[i].a, t[i].d, t[i].err, t[i].rd, 1'b1, w);
            total++;
            if (w !== 0) begin
                bad++;
                $display("FAIL b2b_accept[%0d]: waited %0d cycles, required 0", i, w);
            end
            wait_resp(gv, ge, gd, cyc, ens, rh);
            e = sbq.pop_front();
            total++;
            if (gv !== !e.err || ge !== e.err || cyc !== e.lat || gd !== e.data) begin
                bad++;
                $display("FAIL b2b_resp[%0d]: vld=%b cycle=%0d rdata=%h, required vld=%b cycle=%0d rdata=%h",
                         i, gv, cyc, gd, !e.err, e.lat, e.data);
            end
            total++;
            if (ens !== e.ens || rh !== 0) begin
                bad++;
                $display("FAIL b2b_busy[%0d]: en_cycles=%0d ready_hi=%0d, required %0d 0",
                         i, ens, rh, e.ens);
            end
            step();
            total++;
            if (req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_idle[%0d]: ready=%b, required 1", i, req_ready);
            end
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic gv, ge;
        logic [31:0] gd;
        int cyc, ens, rh, w;
        int vl;
        wq.push_back({8'h20, 8'hDE});
        send(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, w);
        step();
        rst = 1'b1;
        #1;
        total++;
        if ({mem_en, busy, resp_valid, align_err} !== 4'b0000 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rm_abort: en/busy/vld/err=%b rdata=%h, required 0000 00000000",
                     {mem_en, busy, resp_valid, align_err}, resp_rdata);
        end
        vl = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp_valid || align_err || mem_en) vl++;
        end
        rst = 1'b0;
        cur_rd = 32'h0;
        step();
        total++;
        if (vl !== 0 || req_ready !== 1'b1 || wq.size() !== 0) begin
            bad++;
            $display("FAIL rm_quiet: activity=%0d ready=%b pending=%0d, required 0 1 0",
                     vl, req_ready, wq.size());
        end
        total++;
        if (mem[8'h20] !== 8'hDE || mem[8'h21] !== 8'h00) begin
            bad++;
            $display("FAIL rm_partial: mem[20]=%h mem[21]=%h, required de 00",
                     mem[8'h20], mem[8'h21]);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_DE00, 1'b0, w);
        wait_resp(gv, ge, gd, cyc, ens, rh);
        e = sbq.pop_front();
        total++;
        if (gv !== 1'b1 || ge !== 1'b0 || cyc !== e.lat || gd !== e.data || ens !== e.ens) begin
            bad++;
            $display("FAIL rm_after: vld=%b cycle=%0d rdata=%h en=%0d, required 1 %0d %h %0d",
                     gv, cyc, gd, ens, e.lat, e.data, e.ens);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_align_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
